// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multicycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = $clog2(XLEN_DEFAULT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_restore_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] remIn,
  input  logic [XLEN-1:0] quoIn,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remOut,
  output logic [XLEN-1:0] quoOut
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // remIn < divisor always holds, so shifted < 2*divisor and bit XLEN of
  // diff is a clean borrow flag.
  always_comb begin
    shifted = {remIn, quoIn[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[XLEN]) begin
      remOut = shifted[XLEN-1:0];
      quoOut = {quoIn[XLEN-2:0], 1'b0};
    end else begin
      remOut = diff[XLEN-1:0];
      quoOut = {quoIn[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle MULT/DIV sequencer owning HI/LO: radix-2 Booth multiply and
// restoring divide, one step per cycle. MULDIV_UNSIGNED_EN adds MULTU/DIVU.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            multControl,
  input  logic            divControl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
`ifdef MULDIV_UNSIGNED_EN
  input  logic            unsignedOp,
`endif
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            divZero
);

  localparam int CW = (XLEN == XLEN_DEFAULT) ? CNT_W_DEFAULT : $clog2(XLEN);

  muldiv_state_t   state;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] mq;
  logic            qm1;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] rem;
  logic            negQ;
  logic            negR;
  logic            isUns;
  logic            startUns;
  logic            lastStep;

`ifdef MULDIV_UNSIGNED_EN
  assign startUns = unsignedOp;
`else
  assign startUns = 1'b0;
  assign isUns    = 1'b0;
`endif

  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] aMag;
  logic [XLEN-1:0] bMag;

  assign aNeg     = !startUns && a[XLEN-1];
  assign bNeg     = !startUns && b[XLEN-1];
  assign aMag     = aNeg ? (~a + 1'b1) : a;
  assign bMag     = bNeg ? (~b + 1'b1) : b;
  assign lastStep = (cnt == CW'(XLEN - 1));

  // acc is one bit wider than XLEN so that subtracting the most negative
  // multiplicand, or the carry of an unsigned add, cannot overflow.
  logic [XLEN:0]   mcandExt;
  logic [XLEN:0]   boothSum;
  logic [XLEN:0]   accNext;
  logic [XLEN-1:0] mqNext;

  assign mcandExt = isUns ? {1'b0, mcand} : {mcand[XLEN-1], mcand};

  always_comb begin
    boothSum = acc;
    if (isUns) begin
      if (mq[0]) boothSum = acc + mcandExt;
    end else begin
      case ({mq[0], qm1})
        2'b01:   boothSum = acc + mcandExt;
        2'b10:   boothSum = acc - mcandExt;
        default: boothSum = acc;
      endcase
    end
    accNext = {(isUns ? 1'b0 : boothSum[XLEN]), boothSum[XLEN:1]};
    mqNext  = {boothSum[0], mq[XLEN-1:1]};
  end

  logic [XLEN-1:0] remStep;
  logic [XLEN-1:0] quoStep;

  div_restore_step #(.XLEN(XLEN)) uStep (
    .remIn  (rem),
    .quoIn  (mq),
    .divisor(mcand),
    .remOut (remStep),
    .quoOut (quoStep)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mq      <= '0;
      qm1     <= 1'b0;
      mcand   <= '0;
      rem     <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (multControl) begin
            state <= MULT;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            qm1   <= 1'b0;
            mcand <= a;
            mq    <= b;
          end else if (divControl) begin
            if (b == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              divZero <= 1'b1;
            end else begin
              state <= DIV;
              busy  <= 1'b1;
              cnt   <= '0;
              rem   <= '0;
              mcand <= bMag;
              mq    <= aMag;
              negQ  <= aNeg ^ bNeg;
              negR  <= aNeg;
            end
          end
        end
        MULT: begin
          acc <= accNext;
          mq  <= mqNext;
          qm1 <= mq[0];
          if (lastStep) begin
            cnt   <= '0;
            hi    <= accNext[XLEN-1:0];
            lo    <= mqNext;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          rem <= remStep;
          mq  <= quoStep;
          if (lastStep) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          hi    <= negR ? (~rem + 1'b1) : rem;
          lo    <= negQ ? (~mq + 1'b1) : mq;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULDIV_UNSIGNED_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      isUns <= 1'b0;
    end else if ((state == IDLE || state == DONE) && (multControl || divControl)) begin
      isUns <= unsignedOp;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: latency/arithmetic model checked every cycle, plus
// directed cases with literal results and random start traffic.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        multControl;
  logic        divControl;
  logic [31:0] a;
  logic [31:0] b;
  logic        unsignedOp;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divZero;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .multControl(multControl),
    .divControl (divControl),
    .a          (a),
    .b          (b),
`ifdef MULDIV_UNSIGNED_EN
    .unsignedOp (unsignedOp),
`endif
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .divZero    (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  task automatic compute(input bit isMul, input bit u, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy;
    logic [63:0] p;
    sx = u ? longint'({32'b0, x}) : longint'($signed(x));
    sy = u ? longint'({32'b0, y}) : longint'($signed(y));
    if (isMul) begin
      p = 64'(sx * sy);
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      p  = 64'(sx / sy);
      rl = p[31:0];
      p  = 64'(sx % sy);
      rh = p[31:0];
    end
  endtask

  // Model: an accepted op completes a fixed number of edges later.
  int          remaining;
  logic [31:0] expHi, expLo, pendHi, pendLo;
  bit          expBusy, expDone, expDz;
  bit          chkEn = 0;

  always @(posedge clk or negedge reset) begin
    bit mu;
    if (!reset) begin
      remaining = 0;
      expHi = 0; expLo = 0; pendHi = 0; pendLo = 0;
      expBusy = 0; expDone = 0; expDz = 0;
    end else begin
`ifdef MULDIV_UNSIGNED_EN
      mu = unsignedOp;
`else
      mu = 1'b0;
`endif
      expDone = 0;
      expDz   = 0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          expHi = pendHi; expLo = pendLo;
          expDone = 1; expBusy = 0;
        end
      end else if (multControl) begin
        compute(1'b1, mu, a, b, pendHi, pendLo);
        remaining = 32; expBusy = 1;
      end else if (divControl) begin
        if (b == 32'd0) begin
          expDone = 1; expDz = 1;
        end else begin
          compute(1'b0, mu, a, b, pendHi, pendLo);
          remaining = 33; expBusy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("cyc_busy", 64'(busy), 64'(expBusy));
      chk("cyc_done", 64'(done), 64'(expDone));
      chk("cyc_divZero", 64'(divZero), 64'(expDz));
      chk("cyc_hi", 64'(hi), 64'(expHi));
      chk("cyc_lo", 64'(lo), 64'(expLo));
    end
  end

  // Present a start for one cycle, beginning at the current time.
  task automatic drive(input bit m, input bit d, input logic [31:0] x,
                       input logic [31:0] y, input bit u);
    multControl = m; divControl = d; a = x; b = y; unsignedOp = u;
    @(negedge clk);
    multControl = 0; divControl = 0;
  endtask

  task automatic waitDone(input string name, input int expLat);
    int lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk(name, 64'(lat), 64'(expLat));
  endtask

  task automatic runOp(input string name, input bit m, input logic [31:0] x,
                       input logic [31:0] y, input bit u,
                       input logic [31:0] wantHi, input logic [31:0] wantLo);
    @(negedge clk);
    drive(m, !m, x, y, u);
    waitDone({name, "_lat"}, m ? 32 : 33);
    chk({name, "_hi"}, 64'(hi), 64'(wantHi));
    chk({name, "_lo"}, 64'(lo), 64'(wantLo));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [6];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF; sp[5] = 32'h2;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    multControl = 0; divControl = 0; a = 0; b = 0; unsignedOp = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    reset = 1;
    chkEn = 1;

    runOp("mul_7xm3", 1, 32'd7, 32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(negedge clk);
    chk("mul_done_one_cycle", 64'(done), 64'h0);
    runOp("mul_min_sq", 1, 32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h0);
    runOp("div_ovf", 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000);
    runOp("div_m7_2", 0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_7_m2", 0, 32'd7, 32'hFFFFFFFE, 0, 32'h1, 32'hFFFFFFFD);
    runOp("div_setup", 0, 32'h0ACF1234, 32'h2000, 0, 32'h1234, 32'h5678);

    @(negedge clk);
    drive(0, 1, 32'h55, 32'h0, 0);
    waitDone("dz_lat", 0);
    chk("dz_flag", 64'(divZero), 64'h1);
    chk("dz_busy", 64'(busy), 64'h0);
    chk("dz_hi", 64'(hi), 64'h1234);
    chk("dz_lo", 64'(lo), 64'h5678);

    // DIV request during MULT must be ignored.
    @(negedge clk);
    drive(1, 0, 32'h10000, 32'h10003, 0);
    repeat (4) @(negedge clk);
    drive(0, 1, 32'h9, 32'h0, 0);
    waitDone("ign_lat", 27);
    chk("ign_hi", 64'(hi), 64'h1);
    chk("ign_lo", 64'(lo), 64'h30000);
    chk("ign_dz", 64'(divZero), 64'h0);

    // Back-to-back start accepted in the DONE cycle.
    drive(0, 1, 32'd100, 32'd7, 0);
    chk("b2b_busy", 64'(busy), 64'h1);
    chk("b2b_done", 64'(done), 64'h0);
    waitDone("b2b_lat", 33);
    chk("b2b_hi", 64'(hi), 64'd2);
    chk("b2b_lo", 64'(lo), 64'd14);

    // Asynchronous reset in the middle of a MULT.
    @(negedge clk);
    drive(1, 0, 32'h1234567, 32'h89ABCDE, 0);
    repeat (9) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1;

`ifdef MULDIV_UNSIGNED_EN
    runOp("multu", 1, 32'hFFFFFFFF, 32'd2, 1, 32'h1, 32'hFFFFFFFE);
    runOp("divu", 0, 32'hFFFFFFFF, 32'd2, 1, 32'h1, 32'h7FFFFFFF);
`endif

    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 11);
      multControl = (r == 0) || (r == 3);
      divControl  = (r == 1) || (r == 2) || (r == 3);
      a = pick();
      b = pick();
`ifdef MULDIV_UNSIGNED_EN
      unsignedOp = $urandom_range(0, 1) == 1;
`else
      unsignedOp = 0;
`endif
    end
    @(negedge clk);
    multControl = 0; divControl = 0;
    repeat (40) @(negedge clk);
    chkEn = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multicycle multiply/divide sequencer for the MIPS core. It owns the HI/LO registers and runs signed (and optionally unsigned) 32-bit MULT/DIV as iterative operations. The main control FSM pulses `multControl`/`divControl` and stalls on `busy`. The block reports completion with `done` and reports divide-by-zero with `divZero`, which the control FSM routes to the exception path (EPC and `excpControl`).

## Interface
- `XLEN`, default 32: operand width; iteration count equals `XLEN`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `multControl` in 1: start MULT; sampled only when accepting.
- `divControl` in 1: start DIV; sampled only when accepting.
- `a` in XLEN: rs operand (A register), captured at start.
- `b` in XLEN: rt operand (B register), captured at start.
- `unsignedOp` in 1: selects MULTU/DIVU; present only with `MULDIV_UNSIGNED_EN`.
- `hi` out XLEN: HI register.
- `lo` out XLEN: LO register.
- `busy` out 1: operation in progress; control FSM must stall.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result in this cycle.
- `divZero` out 1: one-cycle pulse, DIV with `b == 0`.

## Operation
- States:
  - IDLE
  - MULT (radix-2 Booth, one step per cycle)
  - DIV (restoring division on magnitudes, one step per cycle)
  - FIX (quotient/remainder sign correction, DIV only)
  - DONE
- Accepting states: IDLE and DONE. In any other state, start inputs are ignored with no side effects.
- Simultaneous `multControl` and `divControl`: MULT wins; DIV is dropped.
- MULT result: `{hi,lo}` = full 2·XLEN-bit signed product.
- DIV result:
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, with the sign of the dividend.
  - Magnitudes are computed on |a| and |b|.
- Overflow: 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000 and `hi` = 0, by natural wrap. It is not an exception.
- Divide by zero (`divControl` with `b == 0`): go directly to DONE. `done` = `divZero` = 1 for that one cycle; `hi`/`lo` are unchanged.
- Iteration counter counts 0..XLEN-1. The last step is taken when the counter equals XLEN-1, and the counter then returns to 0.
- `hi`/`lo` change only on the edge entering DONE with a valid result, or on reset.

## Timing
- E0 = edge sampling a start in an accepting state.
- MULT:
  - Edges E1..E32 perform the iterations.
  - `hi`/`lo` are written at E32.
  - `done` = 1 in the cycle after E32.
- DIV:
  - Edges E1..E32 iterate.
  - E33 performs FIX and writes `hi`/`lo`.
  - `done` = 1 in the cycle after E33.
- Divide by zero: `done`/`divZero` = 1 in the cycle after E0.
- `busy` = 1 in MULT/DIV/FIX, 0 in IDLE/DONE. It is registered (state decode) and goes high the cycle after E0.
- Back-to-back: a start seen during DONE is accepted. `done` then deasserts and `busy` rises the next cycle.
- Reset asserted (low), including mid-operation: state = IDLE, counter = 0, `hi` = `lo` = 0, `busy` = `done` = `divZero` = 0, immediately and asynchronously. The partial result is discarded.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_UNSIGNED_EN` defined:
  - The `unsignedOp` port exists and is captured at start.
  - When set, MULT is an unsigned product.
  - When set, DIV skips sign handling; FIX is still traversed, so latency is identical.
- Undefined: the port is absent and all operations are signed.

## Structure
- Shared package `muldiv_pkg` contains:
  - `XLEN` default constant
  - the `muldiv_state_t` enum (IDLE, MULT, DIV, FIX, DONE)
  - the counter width `$clog2(XLEN)`
- One sub-module, `div_restore_step`: combinational single restoring step. It takes the remainder/quotient pair and the divisor, and returns the next pair. It is instantiated once.
- Booth step, FSM, counter and HI/LO registers are inline.

## Test plan
- MULT a = 7, b = 0xFFFFFFFD (−3) → after E32, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB; `done` pulses exactly one cycle; `busy` high E1..E32.
- MULT a = b = 0x80000000 → `hi` = 0x40000000, `lo` = 0. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → after E33, `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIV 7 / −2 → `lo` = 0xFFFFFFFD, `hi` = 1.
- DIV b = 0 with `hi` = 0x1234, `lo` = 0x5678 → next cycle `divZero` = `done` = 1, `busy` never 1, `hi`/`lo` unchanged.
- `divControl` pulsed at iteration 5 of MULT → ignored, MULT result correct. `reset` driven low at iteration 10 → `hi` = `lo` = 0, `busy` = 0 without a clock edge. A start in DONE → accepted back-to-back.
- With `MULDIV_UNSIGNED_EN`:
  - MULTU 0xFFFFFFFF × 2 → `hi` = 1, `lo` = 0xFFFFFFFE.
  - DIVU 0xFFFFFFFF / 2 → `lo` = 0x7FFFFFFF, `hi` = 1.
